if_icache_fetch: RTL

//   Instruction-fetch stage. Consumes pc_out from the PC generator and returns the instruction at that PC.

---
 rtl/if_icache_fetch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/if_icache_fetch.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line icache.
// Misses issue a single word read to the memory controller and stall the pipeline until the line fills.
module if_icache_fetch #(
  parameter int INDEX_LEN   = 7,
  parameter int ICACHE_SIZE = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        branch_or_not,
  input  logic [5:0]  stall_in,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  output logic        if_stall_req,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int TAG_W = 30 - INDEX_LEN;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t state, state_next;

  // Data and tag arrays carry no reset; only the valid bits are cleared.
  logic [31:0]            data_mem [ICACHE_SIZE];
  logic [TAG_W-1:0]       tag_mem  [ICACHE_SIZE];
  logic [ICACHE_SIZE-1:0] valid;

  logic [INDEX_LEN-1:0] idx;
  logic [TAG_W-1:0]     pc_tag;
  logic [INDEX_LEN-1:0] fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 hit;
  logic                 fill_now;
  logic                 hold_if;
  logic                 unused_bits;

  assign idx      = pc_in[INDEX_LEN+1:2];
  assign pc_tag   = pc_in[31:INDEX_LEN+2];
  assign fill_idx = mem_req_addr[INDEX_LEN+1:2];
  assign fill_tag = mem_req_addr[31:INDEX_LEN+2];
  assign hit      = valid[idx] && (tag_mem[idx] == pc_tag);
  assign hold_if  = stall_in[1];
  assign fill_now = rdy_in && (state == MISS) && mem_done;

  // Byte offset of the PC and the other pipeline stages' stall bits are not needed here.
  assign unused_bits = ^{pc_in[1:0], stall_in[5:2], stall_in[0], mem_req_addr[1:0]};

  assign if_stall_req = ((state == IDLE) && !hit) || (state == MISS);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!hit) state_next = MISS;
      MISS:    if (mem_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (fill_now) begin
      data_mem[fill_idx] <= mem_data;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (fill_now) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // The request address is captured once on the miss and held until the fill.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'h0;
    end else if (rdy_in) begin
      if ((state == IDLE) && !hit) begin
        mem_req_valid <= 1'b1;
        mem_req_addr  <= {pc_in[31:2], 2'b00};
      end else if ((state == MISS) && mem_done) begin
        mem_req_valid <= 1'b0;
      end
    end
  end

  // A redirect kills the outgoing instruction regardless of hit or downstream stall.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_valid <= 1'b0;
      inst_out   <= 32'h0;
      inst_pc    <= 32'h0;
    end else if (rdy_in) begin
      if (branch_or_not) begin
        inst_valid <= 1'b0;
      end else if (!hold_if) begin
        if ((state == IDLE) && hit) begin
          inst_valid <= 1'b1;
          inst_out   <= data_mem[idx];
          inst_pc    <= pc_in;
        end else begin
          inst_valid <= 1'b0;
        end
      end
    end
  end

endmodule
